// File: rtl/serial_deshifter.sv
// ---------------------------------------------------------------------------
// serial_deshifter
//
// Collects a serial bit stream (MSB of each word first) into N-bit words and
// presents each completed word on a double-buffered, valid/ready output.
// Bits arrive only in cycles with sin_valid=1, with idle gaps of any length.
// Collection continues while the output holds an unaccepted word. A word
// that completes while that word is still waiting is dropped and the sticky
// overrun flag is raised.
//
// Ports
//   clk       : single clock, all state updates on the rising edge
//   clr       : synchronous active-low reset, highest priority
//   sin       : serial data bit
//   sin_valid : sin is sampled in this cycle
//   sync      : frame restart, discards the partial word (and any bit
//               presented in the same cycle)
//   out_ready : consumer accepts out when out_valid=1 and out_ready=1
//   out       : last completed word, stable while out_valid=1
//   out_valid : out holds a word not yet accepted
//   bit_cnt   : bits of the current partial word collected so far, 0..N-1
//   overrun   : sticky, a completed word was dropped by backpressure
//
// All outputs come straight from flops; there is no input-to-output
// combinational path.
// ---------------------------------------------------------------------------
module serial_deshifter #(
  parameter int N = 16
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   sin,
  input  logic                   sin_valid,
  input  logic                   sync,
  input  logic                   out_ready,
  output logic [N-1:0]           out,
  output logic                   out_valid,
  output logic [$clog2(N):0]     bit_cnt,
  output logic                   overrun
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  // Collection register, kept separate from out so a new word can be
  // gathered while the previous one waits for the consumer.
  logic [N-1:0] sr;

  logic         sample;    // a bit is actually taken this cycle
  logic         complete;  // this sampled bit finishes a word
  logic         accept;    // consumer takes the current out this cycle
  logic [N-1:0] word;      // the word as it will look including this bit

  // A bit presented together with sync belongs to the discarded frame.
  assign sample   = sin_valid && !sync;
  assign complete = sample && (bit_cnt == LAST_BIT);
  assign accept   = out_valid && out_ready;
  assign word     = {sr[N-2:0], sin};

  // NOTE: every register here is a real control/data flop with a defined
  // reset value, and all state is updated with non-blocking assignments so
  // each right-hand side sees the pre-edge values regardless of statement
  // order.
  always_ff @(posedge clk) begin
    if (!clr) begin
      sr        <= '0;
      bit_cnt   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // Input side: frame restart wins over a sampled bit.
      if (sync) begin
        sr      <= '0;
        bit_cnt <= '0;
      end else if (sin_valid) begin
        sr      <= word;
        bit_cnt <= complete ? '0 : bit_cnt + 1'b1;
      end

      // Output side: a completing word may land in the same cycle the old
      // one is accepted; it is only dropped if the old one is still held.
      if (complete) begin
        if (!out_valid || out_ready) begin
          out       <= word;
          out_valid <= 1'b1;
        end else begin
          overrun   <= 1'b1;
        end
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_deshifter.sv
// ---------------------------------------------------------------------------
// tb_serial_deshifter
//
// Bench for serial_deshifter (N=16). A table of words is streamed with and
// without idle gaps and checked on completion; hand-written sequences cover
// backpressure/overrun, back-to-back words, simultaneous accept+completion,
// sync and mid-word reset. Every word the bench expects the consumer to
// accept is pushed to a queue when it is sent; a monitor pops and compares
// on each accept.
// ---------------------------------------------------------------------------
module tb_serial_deshifter;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          clr;
  logic          sin;
  logic          sin_valid;
  logic          sync;
  logic          out_ready;
  logic [N-1:0]  out;
  logic          out_valid;
  logic [4:0]    bit_cnt;
  logic          overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [N-1:0] exp_q[$];

  serial_deshifter #(.N(N)) dut (
    .clk       (clk),
    .clr       (clr),
    .sin       (sin),
    .sin_valid (sin_valid),
    .sync      (sync),
    .out_ready (out_ready),
    .out       (out),
    .out_valid (out_valid),
    .bit_cnt   (bit_cnt),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Inputs change at posedge+1 and are stable through the negedge, so the
  // negedge shows exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (clr === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_accept", 32'(out), 32'hDEAD_BEEF);
      end else begin
        check("accepted_word", 32'(out), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send bits w[hi] down to w[lo]; assumes the collection started at bit 0
  // of this word, so bit_cnt after sending bit i is (N - i) mod N.
  task automatic send_bits(input logic [N-1:0] w, input int hi, input int lo,
                           input int gap);
    logic [4:0] held;
    for (int i = hi; i >= lo; i--) begin
      if (gap > 0 && i != hi) begin
        held      = bit_cnt;
        sin_valid = 1'b0;
        sin       = ~w[i];
        repeat ($urandom_range(gap, 1)) step();
        check("bit_cnt_hold_in_gap", 32'(bit_cnt), 32'(held));
      end
      sin       = w[i];
      sin_valid = 1'b1;
      step();
      check("bit_cnt_step", 32'(bit_cnt), 32'((N - i) % N));
    end
    sin_valid = 1'b0;
  endtask

  task automatic accept_one();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_valid_after_accept", 32'(out_valid), 32'd0);
  endtask

  task automatic do_reset();
    clr = 1'b0;
    step();
    clr = 1'b1;
    exp_q.delete();
    check("rst_out",       32'(out),       32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bit_cnt",   32'(bit_cnt),   32'd0);
    check("rst_overrun",   32'(overrun),   32'd0);
  endtask

  typedef struct {
    logic [N-1:0] word;      // stimulus, sent MSB first
    int           gap;       // max idle cycles between bits (0 = none)
    logic [N-1:0] exp_out;   // expected out on completion
  } vec_t;

  initial begin
    vec_t vecs[6];
    vecs[0] = '{word: 16'hA5C3, gap: 0, exp_out: 16'hA5C3};
    vecs[1] = '{word: 16'hA5C3, gap: 3, exp_out: 16'hA5C3};
    vecs[2] = '{word: 16'h0000, gap: 0, exp_out: 16'h0000};
    vecs[3] = '{word: 16'hFFFF, gap: 2, exp_out: 16'hFFFF};
    vecs[4] = '{word: 16'h8001, gap: 0, exp_out: 16'h8001};
    vecs[5] = '{word: 16'h1234, gap: 1, exp_out: 16'h1234};

    clr = 1'b0; sin = 1'b0; sin_valid = 1'b0; sync = 1'b0; out_ready = 1'b0;
    step();
    do_reset();

    // Table: each word completes with out_ready=0, then is accepted.
    for (int v = 0; v < 6; v++) begin
      send_bits(vecs[v].word, N - 1, 0, vecs[v].gap);
      exp_q.push_back(vecs[v].exp_out);
      check("tbl_out",       32'(out),       32'(vecs[v].exp_out));
      check("tbl_out_valid", 32'(out_valid), 32'd1);
      check("tbl_bit_cnt",   32'(bit_cnt),   32'd0);
      check("tbl_overrun",   32'(overrun),   32'd0);
      step();
      check("tbl_out_held",  32'(out),       32'(vecs[v].exp_out));
      accept_one();
    end

    // Overrun: second word completes while the first is still held.
    send_bits(16'h1234, N - 1, 0, 0);
    exp_q.push_back(16'h1234);
    send_bits(16'hFFFF, N - 1, 0, 0);
    check("ovr_out_kept",  32'(out),       32'h1234);
    check("ovr_valid",     32'(out_valid), 32'd1);
    check("ovr_flag",      32'(overrun),   32'd1);
    accept_one();
    check("ovr_sticky",    32'(overrun),   32'd1);
    repeat (3) step();
    check("ovr_sticky_idle", 32'(overrun), 32'd1);
    do_reset();

    // Back-to-back words with out_ready held high.
    out_ready = 1'b1;
    send_bits(16'h00FF, N - 1, 0, 0);
    exp_q.push_back(16'h00FF);
    check("b2b_first_out",   32'(out),       32'h00FF);
    check("b2b_first_valid", 32'(out_valid), 32'd1);
    send_bits(16'hF00F, N - 1, N - 1, 0);
    check("b2b_gone_after_1", 32'(out_valid), 32'd0);
    send_bits(16'hF00F, N - 2, 0, 0);
    exp_q.push_back(16'hF00F);
    check("b2b_second_out",  32'(out),       32'hF00F);
    check("b2b_second_valid", 32'(out_valid), 32'd1);
    check("b2b_no_overrun",  32'(overrun),   32'd0);
    step();
    check("b2b_second_gone", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Accept and completion in the same cycle: new word replaces old.
    send_bits(16'hC0DE, N - 1, 0, 0);
    exp_q.push_back(16'hC0DE);
    send_bits(16'h5A5A, N - 1, 1, 0);
    out_ready = 1'b1;
    send_bits(16'h5A5A, 0, 0, 0);
    out_ready = 1'b0;
    exp_q.push_back(16'h5A5A);
    check("same_cyc_out",     32'(out),       32'h5A5A);
    check("same_cyc_valid",   32'(out_valid), 32'd1);
    check("same_cyc_overrun", 32'(overrun),   32'd0);
    accept_one();

    // Sync mid-word, with a held output word that sync must not disturb.
    send_bits(16'h1111, N - 1, 0, 0);
    exp_q.push_back(16'h1111);
    send_bits(16'hBEEF, N - 1, 8, 0);
    check("sync_pre_cnt", 32'(bit_cnt), 32'd8);
    sync = 1'b1; sin_valid = 1'b1; sin = 1'b1;
    step();
    sync = 1'b0; sin_valid = 1'b0;
    check("sync_cnt",     32'(bit_cnt),   32'd0);
    check("sync_out",     32'(out),       32'h1111);
    check("sync_valid",   32'(out_valid), 32'd1);
    check("sync_overrun", 32'(overrun),   32'd0);
    accept_one();
    send_bits(16'h8001, N - 1, 0, 0);
    exp_q.push_back(16'h8001);
    check("sync_next_out", 32'(out), 32'h8001);
    accept_one();

    // Reset mid-word while a word is held and overrun is set.
    send_bits(16'h5555, N - 1, 0, 0);
    send_bits(16'hAAAA, N - 1, 0, 0);
    send_bits(16'h3C3C, N - 1, 6, 0);
    check("pre_rst_cnt",     32'(bit_cnt),   32'd10);
    check("pre_rst_valid",   32'(out_valid), 32'd1);
    check("pre_rst_overrun", 32'(overrun),   32'd1);
    sin_valid = 1'b1; sync = 1'b1; out_ready = 1'b1;
    do_reset();
    sin_valid = 1'b0; sync = 1'b0; out_ready = 1'b0;
    send_bits(16'h7E7E, N - 1, 0, 0);
    exp_q.push_back(16'h7E7E);
    check("post_rst_out",   32'(out),       32'h7E7E);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    accept_one();

    repeat (2) step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
